// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit for the EX stage.
// Multiplies finish after MUL_STAGES cycles; divides use a restoring loop, one quotient bit per cycle.
module riscv_muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int MUL_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       func3,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [TAG_W-1:0] tag_in,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] tag_out
);

    localparam int CNT_W = $clog2(XLEN + MUL_STAGES + 1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        func3_q, func3_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvsr_q, dvsr_d;
    logic              negq_q, negq_d;
    logic              negr_q, negr_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TAG_W-1:0]  tagp_q, tagp_d;

    logic              accept;
    logic              a_sgn, b_sgn, div_sgn;
    logic              b_zero, div_ovf;
    logic [2*XLEN-1:0] ext_a, ext_b, prod_full;
    logic [XLEN-1:0]   abs_a, abs_b, special_res;
    logic [XLEN:0]     rem_sh, diff;
    logic [XLEN-1:0]   q_fix, r_fix;

    // low word for MUL (func3=000), high word for all MULH variants
    function automatic logic [XLEN-1:0] mul_sel(input logic [1:0] f, input logic [2*XLEN-1:0] p);
        return (f == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
    endfunction

    always_comb begin
        accept    = start && !flush && (state_q == S_IDLE || state_q == S_DONE);
        a_sgn     = (func3 == 3'b001) || (func3 == 3'b010);
        b_sgn     = (func3 == 3'b001);
        ext_a     = {{XLEN{a_sgn & op_a[XLEN-1]}}, op_a};
        ext_b     = {{XLEN{b_sgn & op_b[XLEN-1]}}, op_b};
        prod_full = ext_a * ext_b;

        div_sgn   = !func3[0];
        b_zero    = (op_b == '0);
        div_ovf   = div_sgn && (op_a == MOST_NEG) && (op_b == '1);
        abs_a     = (div_sgn && op_a[XLEN-1]) ? -op_a : op_a;
        abs_b     = (div_sgn && op_b[XLEN-1]) ? -op_b : op_b;
        if (b_zero)
            special_res = func3[1] ? op_a : '1;
        else
            special_res = func3[1] ? '0 : op_a;

        rem_sh = {rem_q, quo_q[XLEN-1]};
        diff   = rem_sh - {1'b0, dvsr_q};
        q_fix  = negq_q ? -quo_q : quo_q;
        r_fix  = negr_q ? -rem_q : rem_q;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        func3_d  = func3_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvsr_d   = dvsr_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        result_d = result_q;
        tag_d    = tag_q;
        tagp_d   = tagp_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    func3_d = func3[1:0];
                    tagp_d  = tag_in;
                    if (!func3[2]) begin
                        if (MUL_STAGES == 1) begin
                            result_d = mul_sel(func3[1:0], prod_full);
                            tag_d    = tag_in;
                            state_d  = S_DONE;
                        end else begin
                            prod_d  = prod_full;
                            cnt_d   = CNT_W'(MUL_STAGES - 2);
                            state_d = S_MUL;
                        end
                    end else if (b_zero || div_ovf) begin
                        // divide-by-zero and signed overflow resolve without iterating
                        result_d = special_res;
                        tag_d    = tag_in;
                        state_d  = S_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = abs_a;
                        dvsr_d  = abs_b;
                        negq_d  = div_sgn && (op_a[XLEN-1] ^ op_b[XLEN-1]);
                        negr_d  = div_sgn && op_a[XLEN-1];
                        cnt_d   = CNT_W'(XLEN - 1);
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (cnt_q == '0) begin
                    result_d = mul_sel(func3_q, prod_q);
                    tag_d    = tagp_q;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DIV: begin
                // quo_q doubles as the dividend shifter; quotient bits enter at the LSB
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = rem_sh[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                if (cnt_q == '0)
                    state_d = S_FIX;
                else
                    cnt_d = cnt_q - CNT_W'(1);
            end
            S_FIX: begin
                result_d = func3_q[1] ? r_fix : q_fix;
                tag_d    = tagp_q;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        // an aborted op must not disturb the last delivered result
        if (flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
            tag_d    = tag_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            func3_q  <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvsr_q   <= '0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
            tag_q    <= '0;
            tagp_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            func3_q  <= func3_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvsr_q   <= dvsr_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            result_q <= result_d;
            tag_q    <= tag_d;
            tagp_q   <= tagp_d;
        end
    end

    assign busy    = (state_q == S_MUL) || (state_q == S_DIV) || (state_q == S_FIX);
    assign done    = (state_q == S_DONE);
    assign result  = result_q;
    assign tag_out = tag_q;

endmodule

// File: tb/tb_riscv_muldiv_unit.sv
// Self-checking bench for riscv_muldiv_unit (XLEN=32, MUL_STAGES=2): directed plan cases plus
// randomized ops checked against an arithmetic reference model.
module tb_riscv_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  func3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  tag_in = '0;
    logic        flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  tag_out;

    int tests = 0;
    int fails = 0;

    riscv_muldiv_unit #(.XLEN(32), .MUL_STAGES(2), .TAG_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .func3(func3), .op_a(op_a), .op_b(op_b),
        .tag_in(tag_in), .flush(flush), .busy(busy), .done(done), .result(result), .tag_out(tag_out)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain 64-bit arithmetic following the RV32M rules.
    function automatic logic [31:0] ref_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'd0, b});
        case (f3)
            3'd0: begin p = {32'd0, a} * {32'd0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (!f3[2]) return 2;
        if (b == 0) return 1;
        if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Drives one op in the current cycle and returns observations from its done cycle.
    task automatic launch_and_wait(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                   input logic [4:0] tg, output int lat, output bit busy_bad,
                                   output logic [31:0] res, output logic [4:0] tgo);
        start = 1'b1; func3 = f3; op_a = a; op_b = b; tag_in = tg;
        step();
        start = 1'b0; func3 = 3'($urandom); op_a = $urandom; op_b = $urandom; tag_in = 5'($urandom);
        lat = 1;
        busy_bad = 1'b0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy !== 1'b1) busy_bad = 1'b1;
            step();
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        if (busy !== 1'b0) busy_bad = 1'b1;
        res = result;
        tgo = tag_out;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (result !== 32'd0) begin fails++; $display("FAIL reset_result: got %h want 0", result); end
        tests++; if (tag_out !== 5'd0) begin fails++; $display("FAIL reset_tag: got %h want 0", tag_out); end
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_directed();
        logic [2:0]  f3;
        logic [31:0] a, b, exp, res;
        logic [4:0]  tgo;
        int          exp_lat, lat;
        bit          bb;
        for (int i = 0; i < 12; i++) begin
            case (i)
                0:  begin f3 = 3'd0; a = 32'd7;        b = 32'hFFFF_FFFD; exp = 32'hFFFF_FFEB; exp_lat = 2;  end
                1:  begin f3 = 3'd1; a = 32'h8000_0000; b = 32'h8000_0000; exp = 32'h4000_0000; exp_lat = 2;  end
                2:  begin f3 = 3'd3; a = 32'h8000_0000; b = 32'h8000_0000; exp = 32'h4000_0000; exp_lat = 2;  end
                3:  begin f3 = 3'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; exp = 32'hFFFF_FFFF; exp_lat = 2;  end
                4:  begin f3 = 3'd4; a = 32'hFFFF_FFEC; b = 32'd3;        exp = 32'hFFFF_FFFA; exp_lat = 34; end
                5:  begin f3 = 3'd6; a = 32'hFFFF_FFEC; b = 32'd3;        exp = 32'hFFFF_FFFE; exp_lat = 34; end
                6:  begin f3 = 3'd5; a = 32'd100;      b = 32'd7;        exp = 32'd14;        exp_lat = 34; end
                7:  begin f3 = 3'd7; a = 32'd100;      b = 32'd7;        exp = 32'd2;         exp_lat = 34; end
                8:  begin f3 = 3'd5; a = 32'd5;        b = 32'd0;        exp = 32'hFFFF_FFFF; exp_lat = 1;  end
                9:  begin f3 = 3'd6; a = 32'd5;        b = 32'd0;        exp = 32'd5;         exp_lat = 1;  end
                10: begin f3 = 3'd4; a = 32'h8000_0000; b = 32'hFFFF_FFFF; exp = 32'h8000_0000; exp_lat = 1;  end
                default: begin f3 = 3'd6; a = 32'h8000_0000; b = 32'hFFFF_FFFF; exp = 32'd0;   exp_lat = 1;  end
            endcase
            launch_and_wait(f3, a, b, 5'(i + 5), lat, bb, res, tgo);
            tests++; if (lat != exp_lat) begin fails++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, exp_lat); end
            tests++; if (bb) begin fails++; $display("FAIL dir%0d_busy: busy pattern wrong, want high cycles 1..%0d only", i, exp_lat - 1); end
            tests++; if (res !== exp) begin fails++; $display("FAIL dir%0d_result: got %h want %h", i, res, exp); end
            tests++; if (tgo !== 5'(i + 5)) begin fails++; $display("FAIL dir%0d_tag: got %0d want %0d", i, tgo, i + 5); end
            step();
            tests++; if (done !== 1'b0) begin fails++; $display("FAIL dir%0d_done_pulse: got %b want 0", i, done); end
            tests++; if (result !== exp) begin fails++; $display("FAIL dir%0d_result_hold: got %h want %h", i, result, exp); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b, res;
        logic [4:0]  tg, tgo;
        int          lat;
        bit          bb;
        for (int i = 0; i < 60; i++) begin
            f3 = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            tg = 5'($urandom);
            case ($urandom_range(5, 0))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: begin a = $urandom_range(300, 0); b = $urandom_range(20, 1); if ($urandom_range(1, 0) == 1) b = -b; end
                3: b = $urandom_range(3, 1);
                default: ;
            endcase
            launch_and_wait(f3, a, b, tg, lat, bb, res, tgo);
            tests++; if (res !== ref_op(f3, a, b)) begin fails++; $display("FAIL rnd%0d_result f3=%0d a=%h b=%h: got %h want %h", i, f3, a, b, res, ref_op(f3, a, b)); end
            tests++; if (lat != ref_lat(f3, a, b)) begin fails++; $display("FAIL rnd%0d_latency f3=%0d: got %0d want %0d", i, f3, lat, ref_lat(f3, a, b)); end
            tests++; if (tgo !== tg || bb) begin fails++; $display("FAIL rnd%0d_tag_busy: tag got %0d want %0d, busy_bad=%0d want 0", i, tgo, tg, bb); end
            if ($urandom_range(1, 0) == 1) step();
        end
    endtask

    task automatic test_flush();
        logic [31:0] res;
        logic [4:0]  tgo;
        int          lat, ndone;
        bit          bb;
        launch_and_wait(3'd0, 32'd3, 32'd4, 5'd7, lat, bb, res, tgo);
        tests++; if (res !== 32'd12) begin fails++; $display("FAIL flush_setup: got %h want 0000000c", res); end
        step();
        // flush a DIV in cycle 10
        start = 1'b1; func3 = 3'd4; op_a = 32'd1000; op_b = 32'd7; tag_in = 5'd9;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        flush = 1'b1; start = 1'b1; func3 = 3'd0; op_a = 32'd2; op_b = 32'd2; tag_in = 5'd3;
        step();
        flush = 1'b0; start = 1'b0;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL flush_div_stop: busy=%b done=%b want 0 0", busy, done); end
        tests++; if (result !== 32'd12 || tag_out !== 5'd7) begin fails++; $display("FAIL flush_div_hold: got %h/%0d want 0000000c/7", result, tag_out); end
        ndone = 0;
        for (int c = 0; c < 40; c++) begin if (done === 1'b1 || busy === 1'b1) ndone++; step(); end
        tests++; if (ndone != 0) begin fails++; $display("FAIL flush_div_quiet: %0d active cycles want 0", ndone); end
        // flush beats start while idle
        flush = 1'b1; start = 1'b1; func3 = 3'd0; op_a = 32'd5; op_b = 32'd5; tag_in = 5'd2;
        step();
        flush = 1'b0; start = 1'b0;
        ndone = 0;
        for (int c = 0; c < 4; c++) begin if (done === 1'b1 || busy === 1'b1) ndone++; step(); end
        tests++; if (ndone != 0 || result !== 32'd12) begin fails++; $display("FAIL flush_beats_start: active=%0d result=%h want 0 0000000c", ndone, result); end
        // start while busy is ignored
        start = 1'b1; func3 = 3'd5; op_a = 32'd100; op_b = 32'd7; tag_in = 5'd3;
        step();
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat < 100) begin
            if (lat == 5) begin start = 1'b1; func3 = 3'd0; op_a = 32'd6; op_b = 32'd6; tag_in = 5'd1; end
            step();
            start = 1'b0;
            lat++;
        end
        tests++; if (lat != 34) begin fails++; $display("FAIL busy_start_latency: got %0d want 34", lat); end
        tests++; if (result !== 32'd14 || tag_out !== 5'd3) begin fails++; $display("FAIL busy_start_result: got %h/%0d want 0000000e/3", result, tag_out); end
        step();
        ndone = 0;
        for (int c = 0; c < 5; c++) begin if (done === 1'b1) ndone++; step(); end
        tests++; if (ndone != 0) begin fails++; $display("FAIL busy_start_ghost: %0d extra done want 0", ndone); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        start = 1'b1; func3 = 3'd4; op_a = 32'hFFFF_FF00; op_b = 32'd5; tag_in = 5'd11;
        step();
        start = 1'b0;
        for (int c = 1; c < 15; c++) step();
        #2 reset = 1'b0;
        #1;
        tests++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL async_reset_ctl: busy=%b done=%b want 0 0", busy, done); end
        tests++; if (result !== 32'd0 || tag_out !== 5'd0) begin fails++; $display("FAIL async_reset_data: got %h/%0d want 0/0", result, tag_out); end
        step();
        reset = 1'b1;
        ndone = 0;
        for (int c = 0; c < 40; c++) begin if (done === 1'b1 || busy === 1'b1) ndone++; step(); end
        tests++; if (ndone != 0) begin fails++; $display("FAIL async_reset_no_done: %0d active cycles want 0", ndone); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [4:0]  tgo;
        int          lat;
        bit          bb;
        launch_and_wait(3'd0, 32'd10, 32'd10, 5'd4, lat, bb, res, tgo);
        tests++; if (res !== 32'd100 || lat != 2) begin fails++; $display("FAIL b2b_first: got %h lat %0d want 00000064 lat 2", res, lat); end
        launch_and_wait(3'd0, 32'h0000_FFFF, 32'h0000_FFFF, 5'd6, lat, bb, res, tgo);
        tests++; if (res !== 32'hFFFE_0001 || tgo !== 5'd6 || lat != 2) begin fails++; $display("FAIL b2b_mul: got %h/%0d lat %0d want fffe0001/6 lat 2", res, tgo, lat); end
        launch_and_wait(3'd7, 32'd50, 32'd8, 5'd8, lat, bb, res, tgo);
        tests++; if (res !== 32'd2 || lat != 34) begin fails++; $display("FAIL b2b_div: got %h lat %0d want 00000002 lat 34", res, lat); end
        launch_and_wait(3'd5, 32'd9, 32'd0, 5'd12, lat, bb, res, tgo);
        tests++; if (res !== 32'hFFFF_FFFF || tgo !== 5'd12 || lat != 1 || bb) begin fails++; $display("FAIL b2b_special1: got %h/%0d lat %0d want ffffffff/12 lat 1", res, tgo, lat); end
        launch_and_wait(3'd7, 32'd9, 32'd0, 5'd13, lat, bb, res, tgo);
        tests++; if (res !== 32'd9 || tgo !== 5'd13 || lat != 1 || bb) begin fails++; $display("FAIL b2b_special2: got %h/%0d lat %0d want 00000009/13 lat 1", res, tgo, lat); end
        step();
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL b2b_done_end: got %b want 0", done); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
